clk_div_bank: RTL and testbench
===============================

CLK_DIV_BANK -- requirements
Module: clk_div_bank

Interface
- REQ-001: Parameter NUM_CH, default 2, number of independent divider channels (1..8).
- REQ-002: Parameter CNT_W, default 24, width of the divide-ratio and duty fields and of each channel counter.
- REQ-003: Parameter DEF_DIV, default 5_000_000, divide ratio loaded at reset; SHALL fit in CNT_W bits.
- REQ-004: clk_i  input  1  single system clock; all logic on its rising edge.
- REQ-005: rst_i  input  1  reset, synchronous, active-high.
- REQ-006: en_i  input  NUM_CH  per-channel run request.
- REQ-007: load_i  input  NUM_CH  per-channel one-cycle strobe capturing that channel's div_i/duty_i slice.
- REQ-008: div_i  input  NUM_CH*CNT_W  divide ratio; channel c uses bits [c*CNT_W +: CNT_W].
- REQ-009: duty_i  input  NUM_CH*CNT_W  high-phase length in clk_i cycles; same slicing as div_i.
- REQ-010: sync_i  input  1  one-cycle strobe restarting all running channels in phase.
- REQ-011: clk_o  output  NUM_CH  divided clock per channel, registered.
- REQ-012: tick_o  output  NUM_CH  one-cycle pulse, registered, high in the first cycle of each period.
- REQ-013: run_o  output  NUM_CH  high while the channel is in RUN or DRAIN.

Function
- REQ-014: Each channel SHALL hold active regs (div_a, duty_a), pending regs (div_p, duty_p) and a pend flag.
- REQ-015: Effective ratio div_e = max(div_a, 2); effective duty duty_e = duty_a clamped to [1, div_e-1].
- REQ-016: Per-channel FSM states IDLE, RUN, DRAIN.
- REQ-017: IDLE: cnt=0, clk_o=0, tick_o=0; en_i=1 -> RUN with a period start.
- REQ-018: Period start (cycle S): cnt<=0, clk_o<=1, tick_o<=1; if pend=1, div_a<=div_p, duty_a<=duty_p, pend<=0, new values govern that period.
- REQ-019: RUN/DRAIN, non-start cycle: cnt<=cnt+1, clk_o<=((cnt+1) < duty_e), tick_o<=0.
- REQ-020: Wrap when cnt==div_e-1: in RUN -> period start; in DRAIN -> IDLE with clk_o<=0, tick_o<=0, cnt<=0.
- REQ-021: RUN with en_i=0 -> DRAIN; current period completes unchanged (no truncated high or low phase).
- REQ-022: DRAIN with en_i=1 -> RUN, no disturbance to cnt or clk_o.
- REQ-023: load_i[c]=1 in cycle N: div_p/duty_p<=slice values, pend<=1; applied only at the first period start in a cycle later than N; a second load before that overwrites pending.
- REQ-024: sync_i=1: every channel in RUN or DRAIN performs a period start next cycle; DRAIN channels move to RUN only if en_i=1, otherwise remain DRAIN; IDLE channels unaffected.
- REQ-025: Output period SHALL be exactly div_e clk_i cycles; high phase exactly duty_e cycles.
- REQ-026: Channels are fully independent except for sync_i.

Reset
- REQ-027: rst_i=1 at a clock edge: all channels IDLE, cnt=0, clk_o=0, tick_o=0, run_o=0, pend=0, div_a=DEF_DIV, duty_a=DEF_DIV/2, div_p=duty_p=0.
- REQ-028: Reset mid-period SHALL take effect the next edge, overriding en_i, load_i, sync_i; discards pending loads.

Verification
- REQ-029: CNT_W=8, load div=5 duty=2, then en=1 -> clk_o pattern 1,1,0,0,0 repeating; tick_o every 5th cycle aligned to first 1.
- REQ-030: div=4 running, load div=6 duty=3 mid-period -> current period stays 4 cycles; next period 6 cycles with high 3; pend clears at that start.
- REQ-031: en drops at cnt=1 with div=8 duty=4 -> remaining 6 cycles emitted, then clk_o=0, run_o=0; re-raising en during DRAIN gives seamless continuation.
- REQ-032: div=0 duty=0 -> behaves as div=2 duty=1 (toggle every cycle); div=3 duty=7 -> duty clamped to 2.
- REQ-033: Two channels div=3 and div=5 out of phase, pulse sync_i -> both tick_o high next cycle, then periods 3 and 5 from that point.
- REQ-034: rst_i asserted mid-high phase with pending load -> next cycle all outputs 0, IDLE; en=1 afterwards runs with DEF_DIV/2 high phase.

Source files
------------

// File: rtl/clk_div_bank_if.sv
// Control and output bundle for the clock divider bank.
// The bank drives the slave side; the controller drives the master side.
interface clk_div_bank_if #(
   parameter int NUM_CH = 2,
   parameter int CNT_W  = 24
);
   logic [NUM_CH-1:0]       en_i;
   logic [NUM_CH-1:0]       load_i;
   logic [NUM_CH*CNT_W-1:0] div_i;
   logic [NUM_CH*CNT_W-1:0] duty_i;
   logic                    sync_i;
   logic [NUM_CH-1:0]       clk_o;
   logic [NUM_CH-1:0]       tick_o;
   logic [NUM_CH-1:0]       run_o;

   modport master (
      output en_i, load_i, div_i, duty_i, sync_i,
      input  clk_o, tick_o, run_o
   );

   modport slave (
      input  en_i, load_i, div_i, duty_i, sync_i,
      output clk_o, tick_o, run_o
   );
endinterface

// File: rtl/clk_div_bank.sv
// Bank of independent programmable clock dividers with registered
// outputs, glitch-free ratio updates at period boundaries and a common sync.
module clk_div_bank #(
   parameter int NUM_CH  = 2,
   parameter int CNT_W   = 24,
   parameter int DEF_DIV = 5_000_000
) (
   input logic           clk_i,
   input logic           rst_i,
   clk_div_bank_if.slave bus
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      DRAIN = 2'd2
   } state_t;

   localparam logic [CNT_W-1:0] DEF_D = CNT_W'(DEF_DIV);
   localparam logic [CNT_W-1:0] DEF_H = CNT_W'(DEF_DIV / 2);
   localparam logic [CNT_W-1:0] ONE   = CNT_W'(1);
   localparam logic [CNT_W-1:0] TWO   = CNT_W'(2);

   logic [NUM_CH-1:0] clk_v;
   logic [NUM_CH-1:0] tick_v;
   logic [NUM_CH-1:0] run_v;

   assign bus.clk_o  = clk_v;
   assign bus.tick_o = tick_v;
   assign bus.run_o  = run_v;

   for (genvar ch = 0; ch < NUM_CH; ch++) begin : g_ch
      state_t           st, st_n;
      logic [CNT_W-1:0] cnt, cnt_n;
      logic             clk_q, clk_n;
      logic             tick_q, tick_n;
      logic [CNT_W-1:0] div_a, div_an;
      logic [CNT_W-1:0] duty_a, duty_an;
      logic [CNT_W-1:0] div_p, div_pn;
      logic [CNT_W-1:0] duty_p, duty_pn;
      logic             pend, pend_n;
      logic [CNT_W-1:0] div_e;
      logic [CNT_W-1:0] duty_e;
      logic [CNT_W-1:0] cnt_inc;
      logic             wrap;
      logic             start;
      logic             en;

      assign en      = bus.en_i[ch];
      assign div_e   = (div_a < TWO) ? TWO : div_a;
      assign cnt_inc = cnt + ONE;
      assign wrap    = (cnt == div_e - ONE);

      // Duty is clamped so both phases are always at least one cycle.
      always_comb begin
         duty_e = duty_a;
         if (duty_a < ONE)
            duty_e = ONE;
         else if (duty_a > div_e - ONE)
            duty_e = div_e - ONE;
      end

      always_comb begin
         st_n    = st;
         cnt_n   = cnt;
         clk_n   = clk_q;
         tick_n  = 1'b0;
         div_an  = div_a;
         duty_an = duty_a;
         div_pn  = div_p;
         duty_pn = duty_p;
         pend_n  = pend;
         start   = 1'b0;
         unique case (st)
            IDLE: begin
               cnt_n = '0;
               clk_n = 1'b0;
               if (en) begin
                  st_n  = RUN;
                  start = 1'b1;
               end
            end
            RUN, DRAIN: begin
               if (bus.sync_i) begin
                  start = 1'b1;
                  st_n  = en ? RUN : DRAIN;
               end else if (wrap) begin
                  if (en) begin
                     start = 1'b1;
                     st_n  = RUN;
                  end else begin
                     st_n  = IDLE;
                     cnt_n = '0;
                     clk_n = 1'b0;
                  end
               end else begin
                  cnt_n = cnt_inc;
                  clk_n = (cnt_inc < duty_e);
                  st_n  = en ? RUN : DRAIN;
               end
            end
            default: begin
               st_n  = IDLE;
               cnt_n = '0;
               clk_n = 1'b0;
            end
         endcase
         // Pending values from an earlier cycle take over at this start.
         if (start) begin
            cnt_n  = '0;
            clk_n  = 1'b1;
            tick_n = 1'b1;
            if (pend) begin
               div_an  = div_p;
               duty_an = duty_p;
               pend_n  = 1'b0;
            end
         end
         if (bus.load_i[ch]) begin
            div_pn  = bus.div_i[ch*CNT_W +: CNT_W];
            duty_pn = bus.duty_i[ch*CNT_W +: CNT_W];
            pend_n  = 1'b1;
         end
      end

      always_ff @(posedge clk_i) begin
         if (rst_i) begin
            st     <= IDLE;
            cnt    <= '0;
            clk_q  <= 1'b0;
            tick_q <= 1'b0;
            div_a  <= DEF_D;
            duty_a <= DEF_H;
            div_p  <= '0;
            duty_p <= '0;
            pend   <= 1'b0;
         end else begin
            st     <= st_n;
            cnt    <= cnt_n;
            clk_q  <= clk_n;
            tick_q <= tick_n;
            div_a  <= div_an;
            duty_a <= duty_an;
            div_p  <= div_pn;
            duty_p <= duty_pn;
            pend   <= pend_n;
         end
      end

      assign clk_v[ch]  = clk_q;
      assign tick_v[ch] = tick_q;
      assign run_v[ch]  = (st != IDLE);
   end

endmodule

// File: tb/tb_clk_div_bank.sv
// Directed bench for clk_div_bank: two channels, 8-bit fields,
// default ratio 10.
module tb_clk_div_bank;

   localparam int NCH = 2;
   localparam int W   = 8;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   vectors = 0;
   int   miscompares = 0;

   always #5 clk = ~clk;

   clk_div_bank_if #(.NUM_CH(NCH), .CNT_W(W)) bus ();

   clk_div_bank #(
      .NUM_CH (NCH),
      .CNT_W  (W),
      .DEF_DIV(10)
   ) dut (
      .clk_i(clk),
      .rst_i(rst),
      .bus  (bus)
   );

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [7:0] got,
                      input logic [7:0] exp);
      vectors++;
      assert (got === exp) else begin
         miscompares++;
         $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic ld(input int ch, input int d, input int du);
      bus.load_i[ch]       = 1'b1;
      bus.div_i[ch*W +: W]  = W'(d);
      bus.duty_i[ch*W +: W] = W'(du);
   endtask

   task automatic do_reset();
      rst = 1'b1;
      bus.en_i   = '0;
      bus.load_i = '0;
      bus.sync_i = 1'b0;
      cyc();
      rst = 1'b0;
   endtask

   initial begin
      bus.en_i   = '0;
      bus.load_i = '0;
      bus.div_i  = '0;
      bus.duty_i = '0;
      bus.sync_i = 1'b0;

      // reset state
      cyc();
      cyc();
      chk("rst_clk", 8'(bus.clk_o), 8'd0);
      chk("rst_tick", 8'(bus.tick_o), 8'd0);
      chk("rst_run", 8'(bus.run_o), 8'd0);

      // div 5 duty 2
      rst = 1'b0;
      ld(0, 5, 2);
      cyc();
      bus.load_i = '0;
      bus.en_i   = 2'b01;
      cyc();
      for (int i = 0; i < 10; i++) begin
         chk("d5_clk", 8'(bus.clk_o[0]), 8'((i % 5) < 2));
         chk("d5_tick", 8'(bus.tick_o[0]), 8'((i % 5) == 0));
         chk("d5_run", 8'(bus.run_o), 8'd1);
         cyc();
      end

      // ratio change mid-period
      do_reset();
      ld(0, 4, 2);
      cyc();
      bus.load_i = '0;
      bus.en_i   = 2'b01;
      cyc();
      chk("chg_p0", 8'({bus.tick_o[0], bus.clk_o[0]}), 8'b11);
      cyc();
      chk("chg_p1", 8'({bus.tick_o[0], bus.clk_o[0]}), 8'b01);
      ld(0, 6, 3);
      cyc();
      bus.load_i = '0;
      chk("chg_p2", 8'({bus.tick_o[0], bus.clk_o[0]}), 8'b00);
      cyc();
      chk("chg_p3", 8'({bus.tick_o[0], bus.clk_o[0]}), 8'b00);
      cyc();
      for (int i = 0; i < 13; i++) begin
         chk("d6_clk", 8'(bus.clk_o[0]), 8'((i % 6) < 3));
         chk("d6_tick", 8'(bus.tick_o[0]), 8'((i % 6) == 0));
         cyc();
      end

      // drain after en drop at cnt 1
      do_reset();
      ld(0, 8, 4);
      cyc();
      bus.load_i = '0;
      bus.en_i   = 2'b01;
      cyc();
      cyc();
      bus.en_i = 2'b00;
      cyc();
      for (int i = 2; i < 8; i++) begin
         chk("drn_clk", 8'(bus.clk_o[0]), 8'(i < 4));
         chk("drn_run", 8'(bus.run_o[0]), 8'd1);
         cyc();
      end
      chk("drn_end", 8'({bus.run_o[0], bus.tick_o[0], bus.clk_o[0]}),
          8'b000);

      // re-raise en during drain
      bus.en_i = 2'b01;
      cyc();
      chk("rr_p0", 8'({bus.tick_o[0], bus.clk_o[0]}), 8'b11);
      cyc();
      bus.en_i = 2'b00;
      cyc();
      bus.en_i = 2'b01;
      cyc();
      for (int i = 3; i < 8; i++) begin
         chk("rr_clk", 8'(bus.clk_o[0]), 8'(i < 4));
         chk("rr_tick", 8'(bus.tick_o[0]), 8'd0);
         chk("rr_run", 8'(bus.run_o[0]), 8'd1);
         cyc();
      end
      chk("rr_wrap", 8'({bus.tick_o[0], bus.clk_o[0]}), 8'b11);

      // degenerate ratio and duty clamp
      do_reset();
      ld(0, 0, 0);
      cyc();
      bus.load_i = '0;
      bus.en_i   = 2'b01;
      cyc();
      for (int i = 0; i < 4; i++) begin
         chk("d0_clk", 8'(bus.clk_o[0]), 8'((i % 2) == 0));
         chk("d0_tick", 8'(bus.tick_o[0]), 8'((i % 2) == 0));
         cyc();
      end
      ld(0, 3, 7);
      cyc();
      bus.load_i = '0;
      cyc();
      for (int i = 0; i < 6; i++) begin
         chk("d3_clk", 8'(bus.clk_o[0]), 8'((i % 3) < 2));
         chk("d3_tick", 8'(bus.tick_o[0]), 8'((i % 3) == 0));
         cyc();
      end

      // sync two out-of-phase channels
      do_reset();
      ld(0, 3, 1);
      ld(1, 5, 2);
      cyc();
      bus.load_i = '0;
      bus.en_i   = 2'b01;
      cyc();
      bus.en_i = 2'b11;
      cyc();
      cyc();
      cyc();
      chk("pre_sync", 8'(bus.tick_o), 8'b01);
      bus.sync_i = 1'b1;
      cyc();
      bus.sync_i = 1'b0;
      for (int i = 0; i < 15; i++) begin
         chk("s_tick0", 8'(bus.tick_o[0]), 8'((i % 3) == 0));
         chk("s_tick1", 8'(bus.tick_o[1]), 8'((i % 5) == 0));
         chk("s_clk0", 8'(bus.clk_o[0]), 8'((i % 3) < 1));
         chk("s_clk1", 8'(bus.clk_o[1]), 8'((i % 5) < 2));
         cyc();
      end

      // reset mid-high with pending load
      do_reset();
      bus.en_i = 2'b01;
      cyc();
      cyc();
      ld(0, 3, 1);
      cyc();
      bus.load_i = '0;
      chk("mr_high", 8'(bus.clk_o[0]), 8'd1);
      rst = 1'b1;
      cyc();
      chk("mr_out", 8'({bus.run_o, bus.tick_o, bus.clk_o}), 8'd0);
      rst = 1'b0;
      cyc();
      for (int i = 0; i < 11; i++) begin
         chk("mr_clk", 8'(bus.clk_o[0]), 8'((i % 10) < 5));
         chk("mr_tick", 8'(bus.tick_o[0]), 8'((i % 10) == 0));
         cyc();
      end

      $display("== %0d vectors applied, %0d miscompares ==",
               vectors, miscompares);
      $finish;
   end

endmodule
